cla_subtractor_pipe: RTL and testbench

- Two-stage pipelined N-bit subtractor: diff = a - b - bin.
- Implemented as a + ~b + ~bin on 4-bit carry-lookahead groups. Borrow is the inverted carry.
- This is the subtract counterpart of the team's N-bit CLA adder, for datapaths that need registered, flow-controlled subtraction.
- Valid/ready on both sides; one result per cycle at full throughput.

---
 rtl/cla_subtractor_pipe.sv | 131 +++++++++++++
 tb/tb_cla_subtractor_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined N-bit subtractor, diff = a - b - bin, built as
// a + ~b + ~bin on GROUP-bit carry-lookahead groups. The low half is
// summed in the first stage and the high half in the second. Borrow out
// is the inverted final carry. Valid/ready handshake on both sides
// sustains one result per cycle.
// N must be a multiple of 4 and at least 8, and N/2 a multiple of GROUP.
module cla_subtractor_pipe #(
  parameter int N     = 8,
  parameter int GROUP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);

  localparam int H  = N / 2;
  localparam int NG = H / GROUP;

  // Half-width lookahead adder. Each bit carry inside a group is formed
  // directly from generate/propagate terms and the group carry-in. Group
  // carries chain through the group generate/propagate pair.
  function automatic logic [H:0] cla_half(input logic [H-1:0] x,
                                          input logic [H-1:0] y,
                                          input logic         cin);
    logic [H-1:0] g, p, s;
    logic         c_grp, c_bit, term, gg, pp;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    c_grp = cin;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        term = c_grp;
        for (int j = 0; j < i; j++) term = term & p[k*GROUP+j];
        c_bit = term;
        for (int j = 0; j < i; j++) begin
          term = g[k*GROUP+j];
          for (int m = j + 1; m < i; m++) term = term & p[k*GROUP+m];
          c_bit = c_bit | term;
        end
        s[k*GROUP+i] = p[k*GROUP+i] ^ c_bit;
      end
      gg = 1'b0;
      pp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[k*GROUP+i] | (p[k*GROUP+i] & gg);
        pp = pp & p[k*GROUP+i];
      end
      c_grp = gg | (pp & c_grp);
    end
    return {c_grp, s};
  endfunction

  logic         vld_p1;
  logic [H-1:0] lo_p1;
  logic         c_mid_p1;
  logic [H-1:0] a_hi_p1;
  logic [H-1:0] nb_hi_p1;

  logic         accept;
  logic         s1_adv;
  logic         s2_adv;
  logic [H:0]   lo_res;
  logic [H:0]   hi_res;
  logic [N-1:0] diff_n;
  logic         ovf_n;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = vld_p1 & s2_adv;
  assign in_ready = ~rst & (~vld_p1 | s2_adv);
  assign accept   = in_valid & in_ready;

  // Stage 1: low-half sum with inverted subtrahend and inverted borrow-in
  assign lo_res = cla_half(a[H-1:0], ~b[H-1:0], ~bin);

  // Stage 1 occupancy
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (accept) vld_p1 <= 1'b1;
    else if (s1_adv) vld_p1 <= 1'b0;
  end

  // Stage 1 data capture; the high operand halves carry the MSBs needed for ovf
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_p1    <= lo_res[H-1:0];
      c_mid_p1 <= lo_res[H];
      a_hi_p1  <= a[N-1:H];
      nb_hi_p1 <= ~b[N-1:H];
    end
  end

  // Stage 2: high-half sum chained from the registered middle carry
  assign hi_res = cla_half(a_hi_p1, nb_hi_p1, c_mid_p1);
  assign diff_n = {hi_res[H-1:0], lo_p1};
  // Operand signs differ when a's MSB equals the inverted b MSB
  assign ovf_n  = (a_hi_p1[H-1] == nb_hi_p1[H-1]) && (diff_n[N-1] != a_hi_p1[H-1]);

  // Stage 2 occupancy
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else if (s1_adv) out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  // Stage 2 result registers; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (s1_adv) begin
      diff <= diff_n;
      bout <= ~hi_res[H];
      ovf  <= ovf_n;
      zero <= (diff_n == '0);
    end
  end

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Directed bench for cla_subtractor_pipe (N=8): hand-computed vectors,
// a streaming table checked against an arithmetic reference, stall and
// reset scenarios, with an in-order scoreboard on the output side.
module tb_cla_subtractor_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       zero;

  cla_subtractor_pipe #(.N(8), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } res_t;

  res_t exp_cur;
  res_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference, independent of the lookahead structure
  function automatic res_t ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] r;
    res_t       e;
    r    = {1'b0, x} - {1'b0, y} - {8'd0, c};
    e.d  = r[7:0];
    e.bo = r[8];
    e.ov = (x[7] != y[7]) && (r[7] != x[7]);
    e.z  = (r[7:0] == 8'd0);
    return e;
  endfunction

  // Scoreboard: handshakes are evaluated mid-cycle, ahead of the edge that completes them
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_result", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("diff", {24'd0, diff}, {24'd0, e.d});
          check("bout", {31'd0, bout}, {31'd0, e.bo});
          check("ovf",  {31'd0, ovf},  {31'd0, e.ov});
          check("zero", {31'd0, zero}, {31'd0, e.z});
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_cur);
    end
  end

  // Present one beat and return just after the edge that accepts it
  task automatic beat(input logic [7:0] x, input logic [7:0] y, input logic c, input res_t e);
    int waits;
    a        = x;
    b        = y;
    bin      = c;
    exp_cur  = e;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic res_t mk(input logic [7:0] d, input logic bo, input logic ov, input logic z);
    res_t e;
    e.d  = d;
    e.bo = bo;
    e.ov = ov;
    e.z  = z;
    return e;
  endfunction

  initial begin
    int   t0;
    res_t held;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_flags", {29'd0, bout, ovf, zero}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Single beat and latency: valid one edge after capture, not before
    beat(8'hF0, 8'hC0, 1'b0, mk(8'h30, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    idle(2);

    // Signed overflow cases
    beat(8'hAF, 8'h5C, 1'b0, mk(8'h53, 1'b0, 1'b1, 1'b0));
    beat(8'h80, 8'h01, 1'b0, mk(8'h7F, 1'b0, 1'b1, 1'b0));
    // Borrow and zero cases
    beat(8'h00, 8'h01, 1'b0, mk(8'hFF, 1'b1, 1'b0, 1'b0));
    beat(8'h05, 8'h04, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1));
    beat(8'h05, 8'h05, 1'b1, mk(8'hFF, 1'b1, 1'b0, 1'b0));
    // Borrow and overflow together: 0x7F - 0x80 = 0xFF
    beat(8'h7F, 8'h80, 1'b0, mk(8'hFF, 1'b1, 1'b1, 1'b0));
    idle(4);
    check("drain_directed", sb.size(), 32'd0);

    // Stream of 16 back-to-back beats; must take exactly 16 cycles
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] x, y;
      logic       c;
      x = 8'(i * 37 + 11);
      y = 8'((i * 91 + 200) ^ (i << 4));
      c = i[0];
      beat(x, y, c, ref_sub(x, y, c));
    end
    check("stream_cycles", cyc - t0, 32'd16);
    idle(4);
    check("drain_stream", sb.size(), 32'd0);

    // Backpressure: two accepts fill both stages, then in_ready drops
    out_ready = 1'b0;
    beat(8'h10, 8'h20, 1'b0, ref_sub(8'h10, 8'h20, 1'b0));
    beat(8'h90, 8'h11, 1'b1, ref_sub(8'h90, 8'h11, 1'b1));
    a        = 8'h44;
    b        = 8'h44;
    bin      = 1'b0;
    exp_cur  = ref_sub(8'h44, 8'h44, 1'b0);
    held     = ref_sub(8'h10, 8'h20, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_diff", {24'd0, diff}, {24'd0, held.d});
      check("stall_flags", {29'd0, bout, ovf, zero}, {29'd0, held.bo, held.ov, held.z});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    beat(8'h44, 8'h44, 1'b0, ref_sub(8'h44, 8'h44, 1'b0));
    idle(4);
    check("drain_backpressure", sb.size(), 32'd0);

    // Reset with both stages full: in-flight items vanish
    out_ready = 1'b0;
    beat(8'h33, 8'h22, 1'b0, ref_sub(8'h33, 8'h22, 1'b0));
    beat(8'h01, 8'h02, 1'b0, ref_sub(8'h01, 8'h02, 1'b0));
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_diff", {24'd0, diff}, 32'd0);
    check("rst_mid_flags", {29'd0, bout, ovf, zero}, 32'd0);
    check("rst_mid_in_ready_after", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    idle(5);

    // Pipeline still works after the mid-operation reset
    beat(8'h12, 8'h34, 1'b1, ref_sub(8'h12, 8'h34, 1'b1));
    idle(4);
    check("drain_final", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
